// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus bundle for the APB master bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever drives commands and models the APB completer around it.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB requester side
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: takes one read/write command, runs the
// SETUP and ACCESS phases, waits for pready (optionally bounded), and hands
// back read data plus error/timeout status. Every output is a flop.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_master_bridge_if.master  bus
);
    // Wait counter sized to hold TIMEOUT-1 with a spare bit; it saturates
    // so that TIMEOUT=0 (no limit) can sit in ACCESS indefinitely.
    localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT) + 1 : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit                TO_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic               timeout_hit;

    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;
    logic               rsp_timeout_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic               psel_q;
    logic               penable_q;
    logic               pwrite_q;
    logic [DATA_W-1:0]  pwdata_q;

    // Saturating increment of the ACCESS wait counter and the timeout decision.
    always_comb begin
        wait_cnt_d  = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
        timeout_hit = TO_EN && (wait_cnt_q == CNT_LAST);
    end

    // Transfer sequencer; the APB bus and response fields are registered here
    // so that nothing combinational reaches a port.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // paddr/pwrite/pwdata double as the latched command, so
                    // nothing on cmd_* is looked at after this edge.
                    if (cmd_ready_q && bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        paddr_q     <= bus.cmd_addr;
                        pwrite_q    <= bus.cmd_write;
                        pwdata_q    <= bus.cmd_write ? bus.cmd_wdata : '0;
                        wait_cnt_q  <= '0;
                        state_q     <= ST_SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (bus.pready || timeout_hit) begin
                        // Both completions release the bus on the same edge.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        paddr_q     <= '0;
                        pwrite_q    <= 1'b0;
                        pwdata_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                        if (bus.pready) begin
                            rsp_rdata_q   <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                            rsp_err_q     <= bus.pslverr;
                            rsp_timeout_q <= 1'b0;
                        end else begin
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                ST_RESP: begin
                    // Response fields hold until the consumer takes them; the
                    // bridge is ready for a new command on the very next cycle.
                    if (bus.rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.paddr       = paddr_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a 16x8 APB memory completer with programmable
// wait states / hang, a reference memory producing expected responses that are
// queued at command issue and compared when the bridge hands a response back.
module tb_apb_master_bridge;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus)
    );

    // ---------------- APB completer model ----------------
    logic [7:0] slv_mem [16];
    int         acc_cnt     = 0;
    int         wait_cycles = 0;
    logic       hang        = 1'b0;

    assign bus.pready  = bus.psel && bus.penable && !hang && (acc_cnt >= wait_cycles);
    assign bus.pslverr = bus.pready && (bus.paddr >= 32'd16);
    assign bus.prdata  = (bus.paddr < 32'd16) ? slv_mem[bus.paddr[3:0]] : 8'h00;

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && (bus.paddr < 32'd16))
            slv_mem[bus.paddr[3:0]] <= bus.pwdata;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [16];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_rsp    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    endtask

    // mode: 0 normal completion, 1 expect timeout, 2 will be dropped (no entry)
    task automatic push_exp(input logic w, input logic [31:0] a, input logic [7:0] d, input int mode);
        exp_t e;
        if (mode == 2) return;
        if (mode == 1) begin
            e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b1;
        end else if (a >= 32'd16) begin
            e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b0;
        end else if (w) begin
            ref_mem[a[3:0]] = d;
            e.rdata = 8'h00; e.err = 1'b0; e.to = 1'b0;
        end else begin
            e.rdata = ref_mem[a[3:0]]; e.err = 1'b0; e.to = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    // Response monitor: one line per completed transaction.
    always @(negedge pclk) begin
        if (presetn && bus.rsp_valid && bus.rsp_ready) begin
            check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                n_rsp++;
                $display("rsp %0d: rdata=0x%02h err=%0b timeout=%0b (exp 0x%02h %0b %0b)",
                         n_rsp, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                         mon_e.rdata, mon_e.err, mon_e.to);
                check("rsp_rdata",   32'(bus.rsp_rdata),   32'(mon_e.rdata));
                check("rsp_err",     32'(bus.rsp_err),     32'(mon_e.err));
                check("rsp_timeout", 32'(bus.rsp_timeout), 32'(mon_e.to));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] d,
                            input int mode, input logic hold, output int waited);
        logic accepted;
        push_exp(w, a, d, mode);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        waited   = 0;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge pclk);
            if (bus.cmd_ready) accepted = 1'b1;
            else waited++;
            @(posedge pclk); #1;
        end
        if (!accepted) check("cmd_accept", 32'(accepted), 32'd1);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    // Follows SETUP and ACCESS after acceptance; returns at the negedge where
    // the response should first be visible.
    task automatic watch_xfer(input logic [31:0] a, input logic w, input logic [7:0] pwd,
                              input int exp_acc);
        int acc;
        @(negedge pclk);
        check("setup_psel",    32'(bus.psel),    32'd1);
        check("setup_penable", 32'(bus.penable), 32'd0);
        check("setup_paddr",   bus.paddr,        a);
        check("setup_pwrite",  32'(bus.pwrite),  32'(w));
        check("setup_pwdata",  32'(bus.pwdata),  32'(pwd));
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (!(bus.psel && bus.penable)) break;
            acc++;
            if (bus.paddr !== a || bus.pwdata !== pwd)
                check("access_hold", bus.paddr, a);
        end
        check("access_cycles", 32'(acc),           32'(exp_acc));
        check("resp_valid",    32'(bus.rsp_valid), 32'd1);
        check("resp_psel",     32'(bus.psel),      32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge pclk); #1;
        end
        if (sb_q.size() != 0) check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge pclk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 32'd0);
        check({tag, "_apb"}, {bus.psel, bus.penable, bus.pwrite, bus.pwdata}, 32'd0);
        check({tag, "_paddr"}, bus.paddr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, then cmd_ready rises after the first edge out of reset.
        repeat (3) @(posedge pclk);
        #1;
        @(negedge pclk);
        check_all_zero("reset");
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
        @(posedge pclk); #1;

        // Write 0x5 <- 0xA5 with a zero-wait completer, then read it back.
        send_cmd(1'b1, 32'h5, 8'hA5, 0, 1'b0, waited);
        watch_xfer(32'h5, 1'b1, 8'hA5, 1);
        @(posedge pclk); #1;
        drain();
        send_cmd(1'b0, 32'h5, 8'h3C, 0, 1'b0, waited);
        watch_xfer(32'h5, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        drain();

        // Out-of-range address: completer answers with pslverr.
        send_cmd(1'b1, 32'h20, 8'h5A, 0, 1'b0, waited);
        watch_xfer(32'h20, 1'b1, 8'h5A, 1);
        @(posedge pclk); #1;
        drain();
        send_cmd(1'b0, 32'h20, 8'h00, 0, 1'b0, waited);
        watch_xfer(32'h20, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        drain();

        // Timeout: completer never ready, ACCESS must last exactly TIMEOUT cycles.
        hang = 1'b1;
        send_cmd(1'b1, 32'h7, 8'h77, 1, 1'b0, waited);
        watch_xfer(32'h7, 1'b1, 8'h77, TIMEOUT);
        @(posedge pclk); #1;
        hang = 1'b0;
        drain();
        send_cmd(1'b0, 32'h7, 8'h00, 0, 1'b0, waited);
        watch_xfer(32'h7, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        drain();

        // Wait states: pready after 2 ACCESS cycles completes normally.
        wait_cycles = 2;
        send_cmd(1'b1, 32'h7, 8'h77, 0, 1'b0, waited);
        watch_xfer(32'h7, 1'b1, 8'h77, 3);
        @(posedge pclk); #1;
        drain();
        wait_cycles = 0;
        send_cmd(1'b0, 32'h7, 8'h00, 0, 1'b0, waited);
        watch_xfer(32'h7, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        drain();

        // Backpressure: response held, a competing command must not be taken.
        bus.rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h5, 8'h00, 0, 1'b0, waited);
        watch_xfer(32'h5, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h9;
        bus.cmd_wdata = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check("bp_valid",     32'(bus.rsp_valid), 32'd1);
            check("bp_rdata",     32'(bus.rsp_rdata), 32'hA5);
            check("bp_err",       32'(bus.rsp_err),   32'd0);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_psel",      32'(bus.psel),      32'd0);
            @(posedge pclk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        check("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
        check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge pclk); #1;
        drain();
        send_cmd(1'b0, 32'h9, 8'h00, 0, 1'b0, waited);
        watch_xfer(32'h9, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        drain();

        // Reset while in ACCESS: transfer dropped, no response, bus cleared.
        hang = 1'b1;
        send_cmd(1'b1, 32'h3, 8'h33, 2, 1'b0, waited);
        @(negedge pclk);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("mid_access_penable", 32'(bus.penable), 32'd1);
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        hang    = 1'b0;
        @(negedge pclk);
        check_all_zero("midreset");
        @(posedge pclk); #1;
        send_cmd(1'b0, 32'h3, 8'h00, 0, 1'b0, waited);
        watch_xfer(32'h3, 1'b0, 8'h00, 1);
        @(posedge pclk); #1;
        drain();

        // Back-to-back: 16 writes then 16 reads, cmd_valid held high.
        for (int k = 0; k < 32; k++) begin
            logic [7:0] d;
            d = 8'((k % 16) * 37 + 11);
            send_cmd(k < 16, 32'(k % 16), d, 0, 1'b1, waited);
            if (k > 0) check("b2b_gap", 32'(waited), 32'd3);
        end
        bus.cmd_valid = 1'b0;
        drain();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Command-driven APB requester that sits directly upstream of the team's 16x8 APB memory slave.
- Accepts single read/write commands over a valid/ready interface and sequences the APB SETUP and ACCESS phases.
- Waits for pready, with a bounded timeout, then returns read data and error status over a valid/ready response interface.
- Every APB output is registered.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 8, width of write/read data
TIMEOUT, 16, maximum ACCESS cycles to wait for pready; 0 disables the timeout

Ports:
pclk  input  1  clock; all logic on rising edge
presetn  input  1  synchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  bridge can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_W  read data (0 for writes and errors)
rsp_err  output  1  pslverr seen, or timeout
rsp_timeout  output  1  transfer aborted by timeout
paddr  output  ADDR_W  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset (presetn=0 at any rising edge, including mid-transfer):
  - State goes to IDLE.
  - All outputs go to 0: cmd_ready, rsp_*, paddr, psel, penable, pwrite, pwdata.
  - Wait counter clears.
  - Any in-flight transfer is dropped with no response.
  - cmd_ready is 1 from the first cycle after presetn returns high.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; psel=penable=0; paddr/pwrite/pwdata=0.
  - On cmd_valid&&cmd_ready: latch cmd_write/addr/wdata; cmd_ready->0; go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0; paddr=latched addr; pwrite=latched write.
  - pwdata=latched wdata for writes, 0 for reads.
  - Always go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held identical to SETUP.
  - If pready=1:
    - rsp_rdata=prdata for a read with pslverr=0, else 0.
    - rsp_err=pslverr; rsp_timeout=0.
    - Go to RESP; psel/penable/APB buses drop to 0 in the same edge.
  - Else, if TIMEOUT>0 and the wait counter has reached TIMEOUT-1:
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Go to RESP.
    - ACCESS therefore lasts at most TIMEOUT cycles.
  - Else: increment the wait counter (width clog2(TIMEOUT)+1, saturating, cleared on entry to SETUP).
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err/rsp_timeout held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready=1: rsp_valid->0 and rsp_* fields->0 next edge; go to IDLE.
  - psel=0 throughout RESP.
- Latency with a zero-wait slave:
  - Command accepted at edge E0; SETUP visible E0..E1; ACCESS visible E1..E2; rsp_valid visible after E2.
  - Minimum 4 cycles per transaction with rsp_ready tied high (IDLE, SETUP, ACCESS, RESP).
- Commands:
  - cmd_valid while not in IDLE is ignored; cmd_ready=0 guarantees no acceptance.
  - cmd_* values are not sampled after acceptance.
- Outstanding transfers: exactly one at a time; no pipelining.
- pready/pslverr/prdata are sampled only in ACCESS; values in other states are ignored.
- Address range is not checked here. Out-of-range errors come back through pslverr.

Test Plan:
- Write: cmd_write=1, addr=0x5, wdata=0xA5, slave pready in first ACCESS -> psel=1/penable=0 for 1 cycle, then psel=1/penable=1 with paddr=0x5, pwdata=0xA5, pwrite=1; rsp_valid=1, rsp_err=0, rsp_rdata=0x00; a subsequent read of 0x5 returns rsp_rdata=0xA5.
- Invalid address: write to 0x20 -> slave asserts pslverr with pready -> rsp_err=1, rsp_timeout=0; a following read of 0x20 -> rsp_err=1, rsp_rdata=0x00.
- Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0; wait-state variant with pready after 2 ACCESS cycles -> normal response, rsp_timeout=0.
- Backpressure and ignored commands: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, a new cmd_valid is not accepted; rsp_ready=1 -> IDLE next cycle, cmd_ready=1.
- Reset mid-ACCESS: presetn=0 for 1 edge -> next cycle all outputs 0, no rsp_valid; the next command completes normally.
- Back-to-back: 16 writes then 16 reads over addr 0..15, rsp_ready=1, cmd_valid held high -> exactly 4 cycles per transaction; all read data matches written data.
